inst_loop_buffer: RTL and testbench
===================================

Name: inst_loop_buffer

Overview:
- Instruction buffer for the systolic-array controller; successor to the single-range program-counter buffer.
- Streams instructions from an on-chip memory over a valid/ready handshake.
- Adds up to NUM_LOOPS nested zero-overhead hardware loops, wrap or procedural program mode, output back-pressure, and abort.
- Sits between the host/AXI loader (write port) and the instruction decoder (stream port).

Parameters:
INST_BITS, 128, instruction width
ADDR_BITS, 10, memory address / PC width
DEPTH, 1024, instruction memory depth (<= 2**ADDR_BITS)
NUM_LOOPS, 4, loop descriptor count; index 0 = innermost
CNT_BITS, 16, loop iteration count width

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
wea  in  1  memory write enable
addra  in  ADDR_BITS  write address
dina  in  INST_BITS  write data
cfg_we  in  1  loop descriptor write (ignored while busy)
cfg_idx  in  clog2(NUM_LOOPS)  descriptor index
cfg_en  in  1  descriptor enable
cfg_begin  in  ADDR_BITS  loop body first address
cfg_end  in  ADDR_BITS  loop body last address
cfg_count  in  CNT_BITS  iterations (0 treated as 1)
prog_start  in  ADDR_BITS  program first address
prog_end  in  ADDR_BITS  program last address
mode  in  1  1: wrap, 0: procedural
start  in  1  level; rising edge launches run
abort  in  1  synchronous flush to IDLE
inst_valid  out  1  output instruction valid
inst_ready  in  1  consumer ready
inst_data  out  INST_BITS  instruction
inst_pc  out  ADDR_BITS  address of inst_data
busy  out  1  state is RUN or DRAIN
done  out  1  high in DONE until next start/abort

Behaviour:
- Reset: state IDLE; pc = 0; output FIFO empty; inst_valid = 0, inst_data = 0, inst_pc = 0, busy = 0, done = 0; all descriptors disabled, zeroed.
- Memory: simple dual port, 1-cycle read latency. Write and read to the same address in one cycle returns old data. Writes are accepted in any state.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start rising edge -> RUN: pc <= prog_start; remaining[i] <= max(count[i],1) - 1 for all i; done <= 0.
  - start edges are ignored in RUN/DRAIN.
- Output: 2-entry FIFO. A read issues in RUN only when FIFO occupancy + in-flight reads < 2. Each issue launches read of pc and advances pc in the same cycle. Sustained throughput is 1 instr/cycle with inst_ready held high. First inst_valid appears 2 cycles after the start edge.
- Handshake:
  - Transfer when inst_valid && inst_ready.
  - inst_data and inst_pc are stable while inst_valid && !inst_ready.
  - No bubbles are inserted while the FIFO is non-empty.
- Next-pc rule, evaluated at issue, scanning i = 0..NUM_LOOPS-1 (innermost first, enabled descriptors only):
  - pc == end[i] and remaining[i] != 0: pc <= begin[i]; remaining[i]--; remaining[j] reloaded for all j < i; stop scan.
  - pc == end[i] and remaining[i] == 0: remaining[i] reloaded; continue scan.
  - No jump and pc == prog_end:
    - wrap mode: pc <= prog_start and all remaining reloaded.
    - procedural mode: state -> DRAIN.
  - Otherwise: pc <= pc + 1, wrapping modulo 2**ADDR_BITS.
- DRAIN -> DONE when FIFO empty and no read in flight; done <= 1.
- abort (priority over start, in any state): FIFO flushed; in-flight read discarded; inst_valid <= 0; state -> IDLE; done <= 0. Descriptors and memory are retained.
- cfg_we while busy is dropped; no status is reported.

Decomposition:
- Shared package:
  - state encoding (IDLE = 0, RUN = 1, DRAIN = 2, DONE = 3)
  - loop descriptor struct {en, begin, end, count}
  - clog2 function
- Sub-module ib_loop_ctrl owns:
  - descriptors, remaining counters, and the priority scan
  - inputs: pc, issue, reload_all
  - outputs: next_pc, last_issue
- Top level holds memory, FIFO and FSM.

Test Plan:
- Linear, procedural: mem[i] = i; prog 5..8; ready = 1 -> inst_pc 5,6,7,8 on consecutive cycles; done = 1 one cycle after last transfer; busy = 0.
- Single loop: loop0 begin = 2, end = 3, count = 3; prog 0..4 -> pc sequence 0,1,2,3,2,3,2,3,4.
- Nested: loop0 (3..3, count 2), loop1 (2..4, count 2); prog 2..5 -> 2,3,3,4,2,3,3,4,5.
- Back-pressure: ready toggles 1,0,0,1,... on the linear case -> no drop or duplicate; data held stable during stall; order 5..8 preserved.
- Wrap + abort: mode = 1, prog 0..2 -> 0,1,2,0,1,...; abort mid-stream -> inst_valid = 0 next cycle, state IDLE; restart begins again at pc 0.
- Reset mid-run, plus cfg_we during RUN: outputs return to reset values; config write while busy has no effect (verify via next run's sequence).

Source files
------------

// File: rtl/inst_loop_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_loop_buffer_pkg                                                      |
// | Shared types for the instruction loop buffer: FSM state encoding, loop    |
// | descriptor layout and a constant-safe clog2 helper.                       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package inst_loop_buffer_pkg;

    localparam int c_ADDR_BITS = 10;
    localparam int c_CNT_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                   en;
        logic [c_ADDR_BITS-1:0] begin_addr;
        logic [c_ADDR_BITS-1:0] end_addr;
        logic [c_CNT_BITS-1:0]  count;
    } loop_desc_t;

    // Index width for a table of 'value' entries; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ib_loop_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ib_loop_ctrl                                                              |
// | Loop descriptor table, per-loop remaining-iteration counters and the      |
// | innermost-first priority scan that selects the next program counter.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ib_loop_ctrl
    import inst_loop_buffer_pkg::*;
#(
    parameter int ADDR_BITS = c_ADDR_BITS,
    parameter int CNT_BITS  = c_CNT_BITS,
    parameter int NUM_LOOPS = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          cfg_we,
    input  logic [clog2(NUM_LOOPS)-1:0]   cfg_idx,
    input  logic                          cfg_en,
    input  logic [ADDR_BITS-1:0]          cfg_begin,
    input  logic [ADDR_BITS-1:0]          cfg_end,
    input  logic [CNT_BITS-1:0]           cfg_count,
    input  logic [ADDR_BITS-1:0]          prog_start,
    input  logic [ADDR_BITS-1:0]          prog_end,
    input  logic                          mode,
    input  logic [ADDR_BITS-1:0]          pc,
    input  logic                          issue,
    input  logic                          reload_all,
    output logic [ADDR_BITS-1:0]          next_pc,
    output logic                          last_issue
);

    loop_desc_t           r_desc [NUM_LOOPS];
    logic [CNT_BITS-1:0]  r_rem  [NUM_LOOPS];

    logic                 w_jump;
    logic [ADDR_BITS-1:0] w_jump_pc;
    logic [NUM_LOOPS-1:0] w_reload;
    logic [NUM_LOOPS-1:0] w_dec;
    logic                 w_at_end;
    logic                 w_wrap;

    // A count of zero still runs the body once, so it reloads like a count of one.
    function automatic logic [CNT_BITS-1:0] reload_val(input logic [CNT_BITS-1:0] cnt);
        return (cnt == '0) ? '0 : cnt - 1'b1;
    endfunction

    // Innermost-first scan: the first enabled loop ending here with iterations left wins.
    always_comb begin
        w_jump    = 1'b0;
        w_jump_pc = '0;
        w_reload  = '0;
        w_dec     = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            if (!w_jump && r_desc[i].en && (pc == r_desc[i].end_addr)) begin
                if (r_rem[i] != '0) begin
                    w_jump    = 1'b1;
                    w_jump_pc = r_desc[i].begin_addr;
                    w_dec[i]  = 1'b1;
                    for (int j = 0; j < i; j++) begin
                        w_reload[j] = 1'b1;
                    end
                end else begin
                    w_reload[i] = 1'b1;
                end
            end
        end
    end

    assign w_at_end   = !w_jump && (pc == prog_end);
    assign w_wrap     = w_at_end && mode;
    assign last_issue = w_at_end && !mode;
    assign next_pc    = w_jump ? w_jump_pc : (w_wrap ? prog_start : pc + 1'b1);

    // Descriptor table: host writes land here; the top gates writes while busy.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                r_desc[i] <= '0;
            end
        end else if (cfg_we) begin
            r_desc[cfg_idx] <= '{en: cfg_en, begin_addr: cfg_begin,
                                 end_addr: cfg_end, count: cfg_count};
        end
    end

    // Remaining-iteration counters: full reload on launch or wrap, else per-scan update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                r_rem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                if (reload_all || (issue && (w_wrap || w_reload[i]))) begin
                    r_rem[i] <= reload_val(r_desc[i].count);
                end else if (issue && w_dec[i]) begin
                    r_rem[i] <= r_rem[i] - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_loop_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_loop_buffer                                                          |
// | Instruction memory, run-control FSM and 2-entry output FIFO streaming     |
// | instructions to the decoder with nested zero-overhead hardware loops.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module inst_loop_buffer
    import inst_loop_buffer_pkg::*;
#(
    parameter int INST_BITS = 128,
    parameter int ADDR_BITS = c_ADDR_BITS,
    parameter int DEPTH     = 1024,
    parameter int NUM_LOOPS = 4,
    parameter int CNT_BITS  = c_CNT_BITS
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wea,
    input  logic [ADDR_BITS-1:0]          addra,
    input  logic [INST_BITS-1:0]          dina,
    input  logic                          cfg_we,
    input  logic [clog2(NUM_LOOPS)-1:0]   cfg_idx,
    input  logic                          cfg_en,
    input  logic [ADDR_BITS-1:0]          cfg_begin,
    input  logic [ADDR_BITS-1:0]          cfg_end,
    input  logic [CNT_BITS-1:0]           cfg_count,
    input  logic [ADDR_BITS-1:0]          prog_start,
    input  logic [ADDR_BITS-1:0]          prog_end,
    input  logic                          mode,
    input  logic                          start,
    input  logic                          abort,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [INST_BITS-1:0]          inst_data,
    output logic [ADDR_BITS-1:0]          inst_pc,
    output logic                          busy,
    output logic                          done
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ADDR_BITS-1:0] r_pc;
    logic                 r_start_d;

    logic [INST_BITS-1:0] r_mem [DEPTH];
    logic [INST_BITS-1:0] r_rd_data;
    logic [ADDR_BITS-1:0] r_rd_pc;
    logic                 r_rd_vld;

    logic [INST_BITS-1:0] r_fifo_data [2];
    logic [ADDR_BITS-1:0] r_fifo_pc   [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic                 w_start_rise;
    logic                 w_launch;
    logic                 w_pop;
    logic [1:0]           w_occ;
    logic                 w_issue;
    logic [ADDR_BITS-1:0] w_next_pc;
    logic                 w_last_issue;

    assign w_start_rise = start && !r_start_d;
    assign w_launch     = w_start_rise && !abort && ((r_state == IDLE) || (r_state == DONE));
    assign w_pop        = inst_valid && inst_ready;
    // Occupancy after this cycle's pop plus the read landing next cycle; counting the pop
    // lets a read issue every cycle while the consumer keeps up.
    assign w_occ        = r_count - {1'b0, w_pop} + {1'b0, r_rd_vld};
    assign w_issue      = (r_state == RUN) && !abort && (w_occ < 2'd2);

    assign inst_valid = (r_count != 2'd0);
    assign inst_data  = r_fifo_data[r_rd_ptr];
    assign inst_pc    = r_fifo_pc[r_rd_ptr];
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);

    ib_loop_ctrl #(
        .ADDR_BITS (ADDR_BITS),
        .CNT_BITS  (CNT_BITS),
        .NUM_LOOPS (NUM_LOOPS)
    ) u_loop_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_we     (cfg_we && !busy),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_begin  (cfg_begin),
        .cfg_end    (cfg_end),
        .cfg_count  (cfg_count),
        .prog_start (prog_start),
        .prog_end   (prog_end),
        .mode       (mode),
        .pc         (r_pc),
        .issue      (w_issue),
        .reload_all (w_launch),
        .next_pc    (w_next_pc),
        .last_issue (w_last_issue)
    );

    // Next-state logic; abort overrides everything, start edges only count when idle.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (w_start_rise) w_state_nxt = RUN;
                RUN:        if (w_issue && w_last_issue) w_state_nxt = DRAIN;
                DRAIN:      if ((r_count == 2'd0) && !r_rd_vld) w_state_nxt = DONE;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Program counter: loaded on launch, advanced on every issued read.
    always_ff @(posedge clk) begin
        if (!reset_n)      r_pc <= '0;
        else if (w_launch) r_pc <= prog_start;
        else if (w_issue)  r_pc <= w_next_pc;
    end

    // Previous start level for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) r_start_d <= 1'b0;
        else          r_start_d <= start;
    end

    // Memory write port, open in every state.
    always_ff @(posedge clk) begin
        if (wea) r_mem[addra] <= dina;
    end

    // Memory read port; a same-address write in this cycle is not yet visible.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_rd_data <= r_mem[r_pc];
            r_rd_pc   <= r_pc;
        end
    end

    // In-flight read marker; abort discards the pending word.
    always_ff @(posedge clk) begin
        if (!reset_n || abort) r_rd_vld <= 1'b0;
        else                   r_rd_vld <= w_issue;
    end

    // Output FIFO: every returning read is pushed, head pops on handshake.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (abort) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_rd_vld) begin
                r_fifo_data[r_wr_ptr] <= r_rd_data;
                r_fifo_pc[r_wr_ptr]   <= r_rd_pc;
                r_wr_ptr              <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= w_occ;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loop_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_loop_buffer                                                       |
// | Directed and randomized checks of inst_loop_buffer against a queue-based  |
// | program-sequence model with random memory contents and back-pressure.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_inst_loop_buffer;

    localparam int IB = 128;
    localparam int AB = 10;
    localparam int NL = 4;
    localparam int CB = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wea;
    logic [AB-1:0] addra;
    logic [IB-1:0] dina;
    logic          cfg_we;
    logic [1:0]    cfg_idx;
    logic          cfg_en;
    logic [AB-1:0] cfg_begin;
    logic [AB-1:0] cfg_end;
    logic [CB-1:0] cfg_count;
    logic [AB-1:0] prog_start;
    logic [AB-1:0] prog_end;
    logic          mode;
    logic          start;
    logic          abort;
    logic          inst_valid;
    logic          inst_ready;
    logic [IB-1:0] inst_data;
    logic [AB-1:0] inst_pc;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    inst_loop_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_begin  (cfg_begin),
        .cfg_end    (cfg_end),
        .cfg_count  (cfg_count),
        .prog_start (prog_start),
        .prog_end   (prog_end),
        .mode       (mode),
        .start      (start),
        .abort      (abort),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .busy       (busy),
        .done       (done)
    );

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [IB-1:0] model_mem [64];
    bit            m_en    [NL];
    int            m_begin [NL];
    int            m_end   [NL];
    int            m_cnt   [NL];
    int            exp_q   [$];

    task automatic check(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int reload_of(input int c);
        return (c == 0) ? 0 : c - 1;
    endfunction

    // Expected address stream derived from the loop rules on plain integers.
    task automatic build_expected(input int ps, input int pe, input bit wrap, input int limit);
        int pc;
        int nxt;
        int rem [NL];
        bit jumped;
        exp_q.delete();
        for (int i = 0; i < NL; i++) rem[i] = reload_of(m_cnt[i]);
        pc = ps;
        while (exp_q.size() < limit) begin
            exp_q.push_back(pc);
            jumped = 1'b0;
            nxt    = (pc + 1) % 1024;
            for (int i = 0; i < NL; i++) begin
                if (!jumped && m_en[i] && (pc == m_end[i])) begin
                    if (rem[i] != 0) begin
                        nxt = m_begin[i];
                        rem[i]--;
                        for (int j = 0; j < i; j++) rem[j] = reload_of(m_cnt[j]);
                        jumped = 1'b1;
                    end else begin
                        rem[i] = reload_of(m_cnt[i]);
                    end
                end
            end
            if (!jumped && (pc == pe)) begin
                if (!wrap) break;
                nxt = ps;
                for (int i = 0; i < NL; i++) rem[i] = reload_of(m_cnt[i]);
            end
            pc = nxt;
        end
    endtask

    task automatic cfg_write(input int idx, input bit en, input int b, input int e, input int c);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = idx[1:0];
        cfg_en    = en;
        cfg_begin = b[AB-1:0];
        cfg_end   = e[AB-1:0];
        cfg_count = c[CB-1:0];
        @(negedge clk);
        cfg_we    = 1'b0;
        m_en[idx] = en; m_begin[idx] = b; m_end[idx] = e; m_cnt[idx] = c;
    endtask

    task automatic clear_loops();
        for (int i = 0; i < NL; i++) cfg_write(i, 1'b0, 0, 0, 0);
    endtask

    // Launch a run and check n_take transfers against exp_q.
    // rmode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready.
    task automatic run_stream(input string tag, input int ps, input int pe, input bit wrap,
                              input int n_take, input int rmode, input bit chk_done,
                              input int cfg_at);
        int            k;
        int            first;
        int            last;
        int            taken;
        bit            held;
        bit            r;
        logic [IB-1:0] h_data;
        logic [AB-1:0] h_pc;
        prog_start = ps[AB-1:0];
        prog_end   = pe[AB-1:0];
        mode       = wrap;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "/busy_after_start"}, busy, 1'b1);
        check({tag, "/done_clear_after_start"}, done, 1'b0);
        k = 1; first = -1; last = -1; taken = 0; held = 1'b0;
        while ((taken < n_take) && (k < 1000)) begin
            if (held) begin
                check({tag, "/stall_valid"}, inst_valid, 1'b1);
                check({tag, "/stall_pc"}, inst_pc, h_pc);
                check({tag, "/stall_data"}, inst_data, h_data);
            end
            cfg_we    = (k == cfg_at);
            cfg_idx   = 2'd0;
            cfg_en    = 1'b1;
            cfg_begin = '0;
            cfg_end   = 10'd1;
            cfg_count = 16'd5;
            case (rmode)
                0:       r = 1'b1;
                1:       r = ((k % 3) == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            inst_ready = r;
            if (inst_valid && r) begin
                check({tag, "/pc"}, inst_pc, exp_q[taken]);
                check({tag, "/data"}, inst_data, model_mem[exp_q[taken]]);
                if (first < 0) first = k;
                last = k;
                taken++;
            end
            held   = inst_valid && !r;
            h_data = inst_data;
            h_pc   = inst_pc;
            @(negedge clk);
            k++;
        end
        cfg_we = 1'b0;
        check({tag, "/transfer_count_timeout"}, taken, n_take);
        if (rmode == 0) begin
            check({tag, "/first_valid_latency"}, first, 3);
            check({tag, "/back_to_back"}, last - first, n_take - 1);
        end
        if (chk_done) begin
            check({tag, "/done_not_yet"}, done, 1'b0);
            check({tag, "/valid_after_last"}, inst_valid, 1'b0);
            @(negedge clk);
            check({tag, "/done_set"}, done, 1'b1);
            check({tag, "/busy_clear"}, busy, 1'b0);
        end
    endtask

    task automatic do_abort(input string tag);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({tag, "/abort_valid"}, inst_valid, 1'b0);
        check({tag, "/abort_busy"}, busy, 1'b0);
        check({tag, "/abort_done"}, done, 1'b0);
        @(negedge clk);
        check({tag, "/abort_no_late_push"}, inst_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, len, e, b0, e0, b1, e1;
        reset_n = 1'b0; wea = 1'b0; addra = '0; dina = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_begin = '0; cfg_end = '0; cfg_count = '0;
        prog_start = '0; prog_end = '0; mode = 1'b0; start = 1'b0; abort = 1'b0; inst_ready = 1'b0;
        for (int i = 0; i < NL; i++) begin
            m_en[i] = 1'b0; m_begin[i] = 0; m_end[i] = 0; m_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset/valid", inst_valid, 1'b0);
        check("reset/data", inst_data, '0);
        check("reset/pc", inst_pc, '0);
        check("reset/busy", busy, 1'b0);
        check("reset/done", done, 1'b0);

        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            wea   = 1'b1;
            addra = a[AB-1:0];
            dina  = {$urandom, $urandom, $urandom, $urandom};
            model_mem[a] = dina;
        end
        @(negedge clk); wea = 1'b0;

        build_expected(5, 8, 1'b0, 500);
        run_stream("linear", 5, 8, 1'b0, exp_q.size(), 0, 1'b1, -1);

        cfg_write(0, 1'b1, 2, 3, 3);
        build_expected(0, 4, 1'b0, 500);
        check("single/model_len", exp_q.size(), 9);
        run_stream("single", 0, 4, 1'b0, exp_q.size(), 0, 1'b1, -1);
        run_stream("cfg_in_run", 0, 4, 1'b0, exp_q.size(), 0, 1'b1, 4);
        run_stream("cfg_after_run", 0, 4, 1'b0, exp_q.size(), 0, 1'b1, -1);

        cfg_write(0, 1'b1, 3, 3, 2);
        cfg_write(1, 1'b1, 2, 4, 2);
        build_expected(2, 5, 1'b0, 500);
        run_stream("nested", 2, 5, 1'b0, exp_q.size(), 0, 1'b1, -1);

        clear_loops();
        build_expected(5, 8, 1'b0, 500);
        run_stream("backpressure", 5, 8, 1'b0, exp_q.size(), 1, 1'b1, -1);

        build_expected(0, 2, 1'b1, 7);
        run_stream("wrap", 0, 2, 1'b1, 7, 0, 1'b0, -1);
        do_abort("wrap");
        build_expected(0, 2, 1'b1, 5);
        run_stream("wrap_restart", 0, 2, 1'b1, 5, 2, 1'b0, -1);
        do_abort("wrap_restart");

        cfg_write(0, 1'b1, 1, 2, 2);
        build_expected(0, 6, 1'b0, 500);
        run_stream("pre_reset", 0, 6, 1'b0, 3, 2, 1'b0, -1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("midreset/valid", inst_valid, 1'b0);
        check("midreset/data", inst_data, '0);
        check("midreset/pc", inst_pc, '0);
        check("midreset/busy", busy, 1'b0);
        check("midreset/done", done, 1'b0);
        for (int i = 0; i < NL; i++) begin
            m_en[i] = 1'b0; m_begin[i] = 0; m_end[i] = 0; m_cnt[i] = 0;
        end
        build_expected(0, 4, 1'b0, 500);
        run_stream("post_reset", 0, 4, 1'b0, exp_q.size(), 0, 1'b1, -1);

        for (int it = 0; it < 3; it++) begin
            s   = $urandom_range(0, 30);
            len = $urandom_range(3, 8);
            e   = s + len;
            b1  = s + $urandom_range(0, 1);
            e1  = e - $urandom_range(0, 1);
            b0  = $urandom_range(e1, b1);
            e0  = $urandom_range(e1, b0);
            cfg_write(0, 1'b1, b0, e0, $urandom_range(0, 3));
            cfg_write(1, 1'b1, b1, e1, $urandom_range(0, 2));
            build_expected(s, e, 1'b0, 500);
            run_stream("random", s, e, 1'b0, exp_q.size(), 2, 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
